// File: rtl/spi_sub_pkg.sv
// spi_sub_pkg: shared constants and types for the SPI register sub-unit.
//   CMD_WRITE / CMD_READ / CMD_FIFO : command byte encodings
//   state_e                         : protocol FSM states
package spi_sub_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_FIFO  = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WADDR,
        RADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with registered rise/fall detection.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   rise, fall : 1-clk pulses, 3 clk after the raw edge
// INIT is the reset level of the whole chain, so a line that already sits
// at INIT when reset releases produces no spurious edge.
module spi_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta, sync, sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= INIT;
            sync   <= INIT;
            sync_d <= INIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
            fall   <= ~sync & sync_d;
        end
    end

endmodule

// File: rtl/spi_reg_subunit.sv
// spi_reg_subunit: SPI slave with a byte register file and read-only status window.
//   clk, rst_n          : system clock (>= 4x sclk), async active-low reset
//   sclk, mosi, cs      : SPI bus inputs (cs active low), oversampled on clk
//   miso, miso_oe       : SPI data out and pad output enable
//   status_i            : read-only bytes, byte k at address RO_BASE+k
//   regs_o              : RW register contents, byte k = reg[k]
//   wr_strobe/addr/data : one-clk report of each committed RW write
//   rd_strobe           : one-clk pulse per byte loaded for read-out
// Protocol: cmd byte (0A write, 0B read, 0D read without increment),
// address byte, then data bytes with auto-increment until cs rises.
module spi_reg_subunit
    import spi_sub_pkg::*;
#(
    parameter int   DEPTH   = 64,
    parameter int   RO_BASE = 48,
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         mosi,
    input  logic                         cs,
    output logic                         miso,
    output logic                         miso_oe,
    input  logic [(DEPTH-RO_BASE)*8-1:0] status_i,
    output logic [RO_BASE*8-1:0]         regs_o,
    output logic                         wr_strobe,
    output logic [7:0]                   wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         rd_strobe
);

    localparam int NRO = DEPTH - RO_BASE;

    // ---------------- input conditioning ----------------
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_meta, mosi_s;

    spi_sync_edge #(.INIT(CPOL)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs chain resets low: if cs is held low across a reset no fall is
    // seen, so an interrupted transfer cannot resume mid-frame.
    spi_sync_edge #(.INIT(1'b0)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
        end
    end

    logic lead_ev, trail_ev, sample_ev, shift_ev;
    assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
    assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign shift_ev  = CPHA ? lead_ev : trail_ev;

    // ---------------- state ----------------
    state_e                    state_q, state_d;
    logic [2:0]                bit_cnt;
    logic [6:0]                shin;
    logic [7:0]                addr_q;
    logic                      incr_q;
    logic [7:0]                shout;
    logic                      hold_q;
    logic [RO_BASE-1:0][7:0]   regs_q;

    logic [7:0] byte_in;
    logic       byte_done;
    logic [7:0] rd_sel;
    logic [7:0] rd_byte;
    logic       wr_hit;

    assign byte_in   = {shin, mosi_s};
    assign byte_done = sample_ev && (bit_cnt == 3'd7) && (state_q != IDLE) && !cs_rise;
    // During RADDR the address is still in the shifter, so bypass it.
    assign rd_sel    = (state_q == RADDR) ? byte_in : addr_q;
    assign wr_hit    = byte_done && (state_q == WDATA) && (int'(addr_q) < RO_BASE);
    assign regs_o    = regs_q;

    // Read mux: addresses past DEPTH match nothing and read as 0.
    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < RO_BASE; k++)
            if (rd_sel == 8'(k)) rd_byte = regs_q[k];
        for (int k = 0; k < NRO; k++)
            if (rd_sel == 8'(RO_BASE + k)) rd_byte = status_i[k*8 +: 8];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = CMD;
                CMD:   if (byte_done) begin
                           case (byte_in)
                               CMD_WRITE: state_d = WADDR;
                               CMD_READ,
                               CMD_FIFO:  state_d = RADDR;
                               default:   state_d = IGNORE;
                           endcase
                       end
                WADDR: if (byte_done) state_d = WDATA;
                RADDR: if (byte_done) state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        miso = (state_q == RDATA) ? shout[7] : 1'b0;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            shin      <= 7'd0;
            addr_q    <= 8'd0;
            incr_q    <= 1'b0;
            shout     <= 8'd0;
            hold_q    <= 1'b0;
            regs_q    <= '0;
            miso_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            rd_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;

            if (cs_fall) miso_oe <= 1'b1;
            if (cs_rise) miso_oe <= 1'b0;

            if (cs_rise || state_q == IDLE) begin
                bit_cnt <= 3'd0;
                hold_q  <= 1'b0;
            end else begin
                if (sample_ev) begin
                    shin    <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    case (state_q)
                        CMD:   incr_q <= (byte_in == CMD_READ);
                        WADDR: addr_q <= byte_in;
                        WDATA: begin
                            if (wr_hit) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr_q;
                                wr_data   <= byte_in;
                            end
                            addr_q <= addr_q + 8'd1;
                        end
                        RADDR, RDATA: begin
                            shout     <= rd_byte;
                            hold_q    <= 1'b1;
                            rd_strobe <= 1'b1;
                            addr_q    <= rd_sel + {7'd0, incr_q};
                        end
                        default: ;
                    endcase
                end

                // First shift edge after a load keeps the MSB on the line.
                if (shift_ev && state_q == RDATA) begin
                    if (hold_q) hold_q <= 1'b0;
                    else        shout  <= {shout[6:0], 1'b0};
                end
            end

            for (int k = 0; k < RO_BASE; k++)
                if (wr_hit && addr_q == 8'(k)) regs_q[k] <= byte_in;
        end
    end

endmodule

// File: tb/tb_spi_reg_subunit.sv
// Bench for spi_reg_subunit: four instances, one per CPOL/CPHA mode, each
// with its own sclk/cs; mosi and status are shared. Expected read bytes and
// writes are queued before each transfer and popped as the DUT produces them.
module tb_spi_reg_subunit;

    localparam int DEPTH   = 64;
    localparam int RO_BASE = 48;
    localparam int NRO     = DEPTH - RO_BASE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mosi = 1'b0;
    logic [3:0] sclk_v = 4'b1100;
    logic [3:0] cs_v   = 4'b1111;
    logic [NRO*8-1:0] status = {120'h0F0E0D0C0B0A09080706050403_0201, 8'hC3};

    wire [3:0]           miso_w, oe_w, wrs_w, rds_w;
    wire [7:0]           wra_w [4];
    wire [7:0]           wrd_w [4];
    wire [RO_BASE*8-1:0] regs_w [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_subunit #(
            .DEPTH  (DEPTH),
            .RO_BASE(RO_BASE),
            .CPOL   (g >= 2),
            .CPHA   (g % 2 == 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .sclk     (sclk_v[g]),
            .mosi     (mosi),
            .cs       (cs_v[g]),
            .miso     (miso_w[g]),
            .miso_oe  (oe_w[g]),
            .status_i (status),
            .regs_o   (regs_w[g]),
            .wr_strobe(wrs_w[g]),
            .wr_addr  (wra_w[g]),
            .wr_data  (wrd_w[g]),
            .rd_strobe(rds_w[g])
        );
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // ---------------- scoreboards ----------------
    typedef struct { int m; logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    int         rds_cnt[4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rds_w[m] === 1'b1) rds_cnt[m]++;
            if (wrs_w[m] === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_unexpected m%0d: got strobe addr %h data %h, required none",
                             m, wra_w[m], wrd_w[m]);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check($sformatf("wr_mode m%0d", m), 32'(m), 32'(e.m));
                    check($sformatf("wr_addr m%0d", m), 32'(wra_w[m]), 32'(e.a));
                    check($sformatf("wr_data m%0d", m), 32'(wrd_w[m]), 32'(e.d));
                end
            end
        end
    end

    task automatic half();
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Master transfer: tx holds up to 5 bytes MSB-first; bytes at index
    // >= rd_from are compared against rd_q as they complete.
    task automatic xfer(input int m, input logic [39:0] tx, input int nbits, input int rd_from);
        logic       cpol, cpha;
        logic [7:0] rx, e;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        rx = 8'h00;
        cs_v[m] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check($sformatf("oe_on m%0d", m), 32'(oe_w[m]), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) begin
                mosi = tx[39-k];
                half();
                sclk_v[m] = ~cpol;
                rx = {rx[6:0], miso_w[m]};
                half();
                sclk_v[m] = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi = tx[39-k];
                half();
                sclk_v[m] = cpol;
                rx = {rx[6:0], miso_w[m]};
                half();
            end
            if (k % 8 == 7 && k / 8 >= rd_from) begin
                if (rd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_extra m%0d byte%0d: got %h, required no byte", m, k / 8, rx);
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd m%0d byte%0d", m, k / 8), 32'(rx), 32'(e));
                end
            end
        end
        if (!cpha) half();
        cs_v[m] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check($sformatf("oe_off m%0d", m), 32'(oe_w[m]), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          m;
        logic [39:0] tx;
        int          nbits;
        int          rd_from;
        int          nr;
        logic [23:0] rexp;   // first expected read byte in [23:16]
        int          nw;
        logic [31:0] wexp;   // {addr,data} pairs, first in [31:16]
        int          rds;    // expected rd_strobe count, -1 = skip
        int          ca;     // register to check afterwards, -1 = none
        logic [7:0]  cv;
    } vec_t;

    function automatic vec_t mk(int m, logic [39:0] tx, int nbits, int rd_from, int nr,
                                logic [23:0] rexp, int nw, logic [31:0] wexp, int rds,
                                int ca, logic [7:0] cv);
        vec_t v;
        v.m = m; v.tx = tx; v.nbits = nbits; v.rd_from = rd_from; v.nr = nr;
        v.rexp = rexp; v.nw = nw; v.wexp = wexp; v.rds = rds; v.ca = ca; v.cv = cv;
        return v;
    endfunction

    localparam int NV = 19;
    vec_t tbl[NV];

    initial begin
        vec_t v;
        int   base;

        tbl[0]  = mk(0, 40'h0A05A50000, 24, 99, 0, 24'h0,      1, 32'h05A5_0000, 0, 5, 8'hA5);
        tbl[1]  = mk(0, 40'h0B05000000, 24, 2,  1, 24'hA50000, 0, 32'h0,         2, -1, 8'h0);
        tbl[2]  = mk(0, 40'h0A2E112233, 40, 99, 0, 24'h0,      2, 32'h2E11_2F22, 0, 47, 8'h22);
        tbl[3]  = mk(0, 40'h0B2E000000, 40, 2,  3, 24'h1122C3, 0, 32'h0,         4, -1, 8'h0);
        for (int m = 0; m < 4; m++) begin
            tbl[4+2*m] = mk(m, 40'h0A033C0000, 24, 99, 0, 24'h0,      1, 32'h033C_0000, 0, 3, 8'h3C);
            tbl[5+2*m] = mk(m, 40'h0B03000000, 24, 2,  1, 24'h3C0000, 0, 32'h0,         2, -1, 8'h0);
        end
        tbl[12] = mk(0, 40'h0A075A0000, 24, 99, 0, 24'h0,      1, 32'h075A_0000, 0, 7, 8'h5A);
        tbl[13] = mk(0, 40'h0D07000000, 40, 2,  3, 24'h5A5A5A, 0, 32'h0,         4, -1, 8'h0);
        tbl[14] = mk(0, 40'h4205FF0000, 24, 0,  3, 24'h000000, 0, 32'h0,         0, -1, 8'h0);
        tbl[15] = mk(0, 40'h0A09770000, 24, 99, 0, 24'h0,      1, 32'h0977_0000, 0, 9, 8'h77);
        tbl[16] = mk(0, 40'h0A09550000, 21, 99, 0, 24'h0,      0, 32'h0,         0, 9, 8'h77);
        tbl[17] = mk(0, 40'h0A00960000, 24, 99, 0, 24'h0,      1, 32'h0096_0000, 0, 0, 8'h96);
        tbl[18] = mk(0, 40'h0BFE000000, 40, 2,  3, 24'h000096, 0, 32'h0,         4, -1, 8'h0);

        // Reset state
        repeat (5) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("rst_miso m%0d", m), 32'(miso_w[m]), 32'd0);
            check($sformatf("rst_oe m%0d", m),   32'(oe_w[m]),   32'd0);
            check($sformatf("rst_wrs m%0d", m),  32'(wrs_w[m]),  32'd0);
            check($sformatf("rst_rds m%0d", m),  32'(rds_w[m]),  32'd0);
            check($sformatf("rst_wra m%0d", m),  32'(wra_w[m]),  32'd0);
            check($sformatf("rst_wrd m%0d", m),  32'(wrd_w[m]),  32'd0);
            check($sformatf("rst_regs m%0d", m), 32'(|regs_w[m]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            for (int j = 0; j < v.nw; j++)
                wr_q.push_back('{v.m, v.wexp[31-16*j -: 8], v.wexp[23-16*j -: 8]});
            for (int j = 0; j < v.nr; j++)
                rd_q.push_back(v.rexp[23-8*j -: 8]);
            base = rds_cnt[v.m];
            xfer(v.m, v.tx, v.nbits, v.rd_from);
            if (v.rds >= 0)
                check($sformatf("rds_cnt v%0d", i), 32'(rds_cnt[v.m] - base), 32'(v.rds));
            if (v.ca >= 0)
                check($sformatf("reg v%0d a%0d", i, v.ca), 32'(regs_w[v.m][v.ca*8 +: 8]), 32'(v.cv));
            check($sformatf("rdq_empty v%0d", i), 32'(rd_q.size()), 32'd0);
            check($sformatf("wrq_empty v%0d", i), 32'(wr_q.size()), 32'd0);
        end

        // Earlier writes survive the later traffic
        check("reg5_keep", 32'(regs_w[0][5*8 +: 8]), 32'hA5);
        check("reg2E_keep", 32'(regs_w[0][46*8 +: 8]), 32'h11);

        // Reset in the middle of a read data byte, cs kept low across it
        fork
            xfer(0, 40'h0B05000000, 40, 99);
            begin
                repeat (360) @(posedge clk);
                #1;
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("midrst_miso", 32'(miso_w[0]), 32'd0);
                check("midrst_oe", 32'(oe_w[0]), 32'd0);
                rst_n = 1'b1;
                repeat (50) @(negedge clk);
                check("postrst_oe", 32'(oe_w[0]), 32'd0);
                check("postrst_miso", 32'(miso_w[0]), 32'd0);
            end
        join
        check("postrst_regs", 32'(|regs_w[0]), 32'd0);

        // Fresh frame after reset works again
        wr_q.push_back('{0, 8'h05, 8'h66});
        xfer(0, 40'h0A05660000, 24, 99);
        rd_q.push_back(8'h66);
        xfer(0, 40'h0B05000000, 24, 2);
        check("resume_rdq", 32'(rd_q.size()), 32'd0);
        check("resume_wrq", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
